// File: rtl/weight_ram_loader.sv
// weight_ram_loader
//   Write-side controller for the per-filter weight RAM. Converts a
//   filter-major valid/ready stream of weight and bias words into RAM
//   write strobes with a depth address (filter) and a lane select (feature).
//
// Ports:
//   Clk, Reset           clock, synchronous active-high reset
//   Start                one-cycle pulse, begins a load when idle
//   In_valid/In_data     incoming word stream
//   In_ready             high while loading (combinational from state)
//   Write_en             registered RAM write strobe, one cycle per word
//   Address_depth_write  filter index of the word being written
//   Address_width_write  lane index of the word being written
//   Write_data_in        word being written
//   Busy                 load in progress (LOAD or DONE)
//   Load_done            one-cycle pulse after the final word is accepted
//   Weights_ready        level, RAM fully loaded since the last Start/Reset
module weight_ram_loader #(
  parameter int Bit_width            = 8,
  parameter int Nr_depth             = 8,
  parameter int Depth_counter_bits   = 3,
  parameter int Nr_feature           = 6,
  parameter int Feature_counter_bits = 3
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            Start,
  input  logic                            In_valid,
  input  logic [Bit_width-1:0]            In_data,
  output logic                            In_ready,
  output logic                            Write_en,
  output logic [Depth_counter_bits-1:0]   Address_depth_write,
  output logic [Feature_counter_bits-1:0] Address_width_write,
  output logic [Bit_width-1:0]            Write_data_in,
  output logic                            Busy,
  output logic                            Load_done,
  output logic                            Weights_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  localparam logic [Depth_counter_bits-1:0]   DEPTH_LAST = Depth_counter_bits'(Nr_depth - 1);
  localparam logic [Feature_counter_bits-1:0] FEAT_LAST  = Feature_counter_bits'(Nr_feature - 1);

  state_e                          state_q, state_d;
  logic [Depth_counter_bits-1:0]   depth_q, depth_d;
  logic [Feature_counter_bits-1:0] feat_q, feat_d;
  logic                            wen_q, wen_d;
  logic [Depth_counter_bits-1:0]   addr_depth_q, addr_depth_d;
  logic [Feature_counter_bits-1:0] addr_lane_q, addr_lane_d;
  logic [Bit_width-1:0]            data_q, data_d;
  logic                            wready_q, wready_d;

  logic accept;
  logic last_word;

  assign accept    = In_valid && (state_q == S_LOAD);
  assign last_word = (depth_q == DEPTH_LAST) && (feat_q == FEAT_LAST);

  // State register plus registered datapath
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      depth_q      <= '0;
      feat_q       <= '0;
      wen_q        <= 1'b0;
      addr_depth_q <= '0;
      addr_lane_q  <= '0;
      data_q       <= '0;
      wready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      feat_q       <= feat_d;
      wen_q        <= wen_d;
      addr_depth_q <= addr_depth_d;
      addr_lane_q  <= addr_lane_d;
      data_q       <= data_d;
      wready_q     <= wready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (Start) state_d = S_LOAD;
      S_LOAD:  if (accept && last_word) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter, write-port and Weights_ready updates
  always_comb begin
    depth_d      = depth_q;
    feat_d       = feat_q;
    wen_d        = 1'b0;
    addr_depth_d = addr_depth_q;
    addr_lane_d  = addr_lane_q;
    data_d       = data_q;
    wready_d     = wready_q;

    if ((state_q == S_IDLE) && Start) begin
      depth_d  = '0;
      feat_d   = '0;
      wready_d = 1'b0;
    end

    if (accept) begin
      wen_d        = 1'b1;
      addr_depth_d = depth_q;
      addr_lane_d  = feat_q;
      data_d       = In_data;
      if (feat_q == FEAT_LAST) begin
        feat_d = '0;
        // Explicit wrap so a non-power-of-two depth never overruns
        depth_d = (depth_q == DEPTH_LAST) ? '0 : depth_q + 1'b1;
      end else begin
        feat_d = feat_q + 1'b1;
      end
    end

    if (state_q == S_DONE) wready_d = 1'b1;
  end

  // Outputs decoded from state
  always_comb begin
    In_ready  = (state_q == S_LOAD);
    Busy      = (state_q != S_IDLE);
    Load_done = (state_q == S_DONE);
  end

  assign Write_en            = wen_q;
  assign Address_depth_write = addr_depth_q;
  assign Address_width_write = addr_lane_q;
  assign Write_data_in       = data_q;
  assign Weights_ready       = wready_q;

endmodule

// File: tb/tb_weight_ram_loader.sv
module tb_weight_ram_loader;

  localparam int BW = 8;
  localparam int ND = 8;
  localparam int DB = 3;
  localparam int NF = 6;
  localparam int FB = 3;
  localparam int NW = ND * NF;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic          In_valid = 1'b0;
  logic [BW-1:0] In_data = '0;
  logic          In_ready;
  logic          Write_en;
  logic [DB-1:0] Address_depth_write;
  logic [FB-1:0] Address_width_write;
  logic [BW-1:0] Write_data_in;
  logic          Busy;
  logic          Load_done;
  logic          Weights_ready;

  weight_ram_loader #(
    .Bit_width(BW), .Nr_depth(ND), .Depth_counter_bits(DB),
    .Nr_feature(NF), .Feature_counter_bits(FB)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .In_valid(In_valid),
    .In_data(In_data), .In_ready(In_ready), .Write_en(Write_en),
    .Address_depth_write(Address_depth_write),
    .Address_width_write(Address_width_write),
    .Write_data_in(Write_data_in), .Busy(Busy), .Load_done(Load_done),
    .Weights_ready(Weights_ready)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [DB-1:0] depth;
    logic [FB-1:0] lane;
    logic [BW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vec = 0;
  int  errs = 0;
  int  writes_seen = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a write must appear exactly in the cycle after each accept
  always @(negedge Clk) begin
    if (mon_en) begin
      check("write_en_timing", 32'(Write_en), 32'(exp_q.size() != 0));
      if (Write_en === 1'b1 && exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        writes_seen++;
        check("wr_depth", 32'(Address_depth_write), 32'(e.depth));
        check("wr_lane",  32'(Address_width_write), 32'(e.lane));
        check("wr_data",  32'(Write_data_in),       32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"}, 32'(In_ready), 0);
    check({tag, "_write_en"}, 32'(Write_en), 0);
    check({tag, "_depth"},    32'(Address_depth_write), 0);
    check({tag, "_lane"},     32'(Address_width_write), 0);
    check({tag, "_data"},     32'(Write_data_in), 0);
    check({tag, "_busy"},     32'(Busy), 0);
    check({tag, "_load_done"}, 32'(Load_done), 0);
    check({tag, "_wready"},   32'(Weights_ready), 0);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_wready_drop", 32'(Weights_ready), 0);
    check("start_busy", 32'(Busy), 1);
  endtask

  function automatic logic [BW-1:0] word_data(input int dmode, input int n);
    case (dmode)
      0:       return BW'(n);
      1:       return BW'(255 - n);
      default: return BW'($urandom);
    endcase
  endfunction

  // vmode: 0 continuous, 1 pattern 1,0,0,1, 2 random gaps
  // spur_at: Start pulsed alongside word spur_at; rst_at: Reset after word rst_at
  task automatic run_load(input int vmode, input int dmode, input int spur_at,
                          input int rst_at, input string tag);
    int n = 0;
    int c = 0;
    int w0 = writes_seen;
    logic v;
    logic [BW-1:0] d;
    while (n < NW && c < 2000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = ((c % 4) == 0) || ((c % 4) == 3);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      d = word_data(dmode, n);
      In_valid = v;
      In_data  = d;
      Start    = (v && n == spur_at);
      @(negedge Clk);
      #1;
      check({tag, "_in_ready"}, 32'(In_ready), 1);
      check({tag, "_busy"}, 32'(Busy), 1);
      check({tag, "_load_done_early"}, 32'(Load_done), 0);
      @(posedge Clk);
      if (v) begin
        wr_t e;
        e.depth = DB'(n / NF);
        e.lane  = FB'(n % NF);
        e.data  = d;
        exp_q.push_back(e);
        n++;
      end
      #1;
      In_valid = 1'b0;
      Start    = 1'b0;
      c++;
      if (rst_at >= 0 && n == rst_at + 1) begin
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_idle_zero({tag, "_midrst"});
        return;
      end
    end
    check({tag, "_cycle_budget"}, 32'(n), NW);
    @(negedge Clk);
    #1;
    check({tag, "_done_pulse"}, 32'(Load_done), 1);
    check({tag, "_done_in_ready"}, 32'(In_ready), 0);
    check({tag, "_done_busy"}, 32'(Busy), 1);
    check({tag, "_done_wready"}, 32'(Weights_ready), 0);
    check({tag, "_write_count"}, 32'(writes_seen - w0), NW);
    tick();
    check({tag, "_done_clear"}, 32'(Load_done), 0);
    check({tag, "_wready_set"}, 32'(Weights_ready), 1);
    check({tag, "_idle_busy"}, 32'(Busy), 0);
    check({tag, "_idle_in_ready"}, 32'(In_ready), 0);
    repeat (2) tick();
    check({tag, "_wready_hold"}, 32'(Weights_ready), 1);
  endtask

  initial begin
    // Reset with Start and In_valid asserted: reset must win
    Reset = 1'b1;
    Start = 1'b1;
    In_valid = 1'b1;
    In_data = 8'hA5;
    repeat (2) tick();
    Reset = 1'b0;
    Start = 1'b0;
    In_valid = 1'b0;
    check_idle_zero("reset");
    mon_en = 1'b1;

    // Valid without Start in IDLE does nothing
    In_valid = 1'b1;
    repeat (3) tick();
    In_valid = 1'b0;
    check("idle_no_busy", 32'(Busy), 0);

    pulse_start();
    run_load(0, 0, -1, -1, "cont");

    pulse_start();
    run_load(1, 0, -1, -1, "bp");

    pulse_start();
    run_load(0, 0, 21, -1, "spur");

    pulse_start();
    run_load(0, 0, -1, 30, "rstmid");
    check("rstmid_queue_empty", 32'(exp_q.size()), 0);

    pulse_start();
    run_load(2, 2, -1, -1, "rand");

    pulse_start();
    run_load(0, 1, -1, -1, "reload");

    for (int i = 0; i < 2; i++) begin
      pulse_start();
      run_load(2, 2, $urandom_range(0, NW - 1), -1, "randspur");
    end

    repeat (3) tick();
    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
